// File: rtl/gbsha_ttfir_pkg.sv
// Shared definitions for the 4-tap FIR slice: default widths and the collector phase encoding.
package gbsha_ttfir_pkg;

  localparam int DEF_N_TAPS     = 4;
  localparam int DEF_BW_SUM     = 14;
  localparam int DEF_BW_OUT     = 8;
  localparam int DEF_FIFO_DEPTH = 4;

  typedef enum logic [1:0] {
    SETUP = 2'd0,
    SKIP  = 2'd1,
    MSB   = 2'd2,
    LSB   = 2'd3
  } phase_e;

endpackage

// File: rtl/gbsha_ttfir_fifo.sv
// Synchronous show-ahead FIFO; wrap-bit pointers, a push into a full FIFO is dropped unless a pop shares the edge.
module gbsha_ttfir_fifo #(
  parameter int WIDTH = 14,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage carries data only, so it is left out of reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/gbsha_ttfir_collect.sv
// Collector behind the FIR: tracks its post-reset phases, rebuilds results from output bytes, queues them for a consumer.
module gbsha_ttfir_collect
  import gbsha_ttfir_pkg::*;
#(
  parameter int N_TAPS     = DEF_N_TAPS,
  parameter int BW_SUM     = DEF_BW_SUM,
  parameter int BW_OUT     = DEF_BW_OUT,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [BW_OUT-1:0]        y_in,
  input  logic                     lsb_mode,
  output logic signed [BW_SUM-1:0] res_data,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic                     overflow,
  output logic                     running
);

  localparam int CNT_W = $clog2(N_TAPS + 1);
  localparam int LO_W  = BW_SUM - BW_OUT;

  // Single-byte mode: the byte is the top of the sum, low bits lost.
  function automatic logic signed [BW_SUM-1:0] join_msb(input logic [BW_OUT-1:0] b);
    logic signed [BW_SUM-1:0] r;
    r = BW_SUM'(signed'(b)) <<< LO_W;
    return r;
  endfunction

  // Two-byte mode: the LSB byte overlaps the MSB byte; only its low bits are new.
  function automatic logic signed [BW_SUM-1:0] join_pair(input logic [BW_OUT-1:0] hi,
                                                         input logic [BW_OUT-1:0] lo);
    return signed'({hi, lo[LO_W-1:0]});
  endfunction

  phase_e                   state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic                     mode_q;
  logic [BW_OUT-1:0]        msb_q;
  logic signed [BW_SUM-1:0] hold_q;
  logic                     push;
  logic signed [BW_SUM-1:0] push_data;
  logic                     pop;
  logic [BW_SUM-1:0]        head;
  logic                     empty;
  logic                     full;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= SETUP;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    push      = 1'b0;
    push_data = join_msb(y_in);
    case (state_q)
      SETUP: begin
        if (cnt_q == CNT_W'(N_TAPS)) state_d = SKIP;
        else                         cnt_d   = cnt_q + 1'b1;
      end
      SKIP: state_d = MSB;
      MSB: begin
        if (mode_q) state_d = LSB;
        else        push    = 1'b1;
      end
      LSB: begin
        push      = 1'b1;
        push_data = join_pair(msb_q, y_in);
        state_d   = MSB;
      end
      default: state_d = SETUP;
    endcase
  end

  // Mode is taken once at the first setup edge and held until the next reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_q <= 1'b0;
      msb_q  <= '0;
    end else begin
      if (state_q == SETUP && cnt_q == '0) mode_q <= lsb_mode;
      if (state_q == MSB)                  msb_q  <= y_in;
    end
  end

  gbsha_ttfir_fifo #(
    .WIDTH(BW_SUM),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .reset(reset),
    .push (push),
    .pop  (pop),
    .din  (push_data),
    .dout (head),
    .empty(empty),
    .full (full)
  );

  assign res_valid = !empty;
  assign pop       = res_valid && res_ready;
  assign running   = (state_q == MSB) || (state_q == LSB);

  // Once drained, the last handed-out result stays on res_data instead of stale storage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) hold_q <= '0;
    else if (pop) hold_q <= signed'(head);
  end

  assign res_data = empty ? hold_q : signed'(head);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) overflow <= 1'b0;
    else if (push && full && !pop) overflow <= 1'b1;
  end

endmodule

// File: tb/tb_gbsha_ttfir_collect.sv
// Directed bench for the FIR result collector: phases, byte reassembly, FIFO flow control and reset.
module tb_gbsha_ttfir_collect;

  logic               clk;
  logic               reset;
  logic [7:0]         y_in;
  logic               lsb_mode;
  logic signed [13:0] res_data;
  logic               res_valid;
  logic               res_ready;
  logic               overflow;
  logic               running;

  int checks;
  int failures;

  gbsha_ttfir_collect dut (
    .clk      (clk),
    .reset    (reset),
    .y_in     (y_in),
    .lsb_mode (lsb_mode),
    .res_data (res_data),
    .res_valid(res_valid),
    .res_ready(res_ready),
    .overflow (overflow),
    .running  (running)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Reset for one edge; the first posedge after return is edge 0.
  task automatic do_reset(input logic mode);
    @(negedge clk);
    reset    = 1'b1;
    lsb_mode = mode;
    y_in     = 8'h00;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if (res_valid !== 1'b0 || res_data !== 14'h0000 || overflow !== 1'b0 || running !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs got v=%b d=%h o=%b r=%b exp v=0 d=0000 o=0 r=0",
               res_valid, res_data, overflow, running);
    end
  endtask

  task automatic test_mode0_basic;
    do_reset(1'b0);
    y_in      = 8'h05;
    res_ready = 1'b1;
    tick(5);
    checks++;
    if (running !== 1'b0) begin
      failures++;
      $display("FAIL m0_running_edge4 got %b exp 0", running);
    end
    tick();
    checks++;
    if (running !== 1'b1 || res_valid !== 1'b0) begin
      failures++;
      $display("FAIL m0_edge5 got running=%b valid=%b exp running=1 valid=0", running, res_valid);
    end
    tick();
    checks++;
    if (res_valid !== 1'b1 || res_data !== 14'h0140) begin
      failures++;
      $display("FAIL m0_first_result got valid=%b data=%h exp valid=1 data=0140", res_valid, res_data);
    end
  endtask

  task automatic test_mode1_latch;
    do_reset(1'b1);
    res_ready = 1'b0;
    tick();
    lsb_mode = 1'b0;
    tick(5);
    y_in = 8'hFE;
    tick();
    checks++;
    if (res_valid !== 1'b0) begin
      failures++;
      $display("FAIL m1_no_push_msb got valid=%b exp 0", res_valid);
    end
    y_in = 8'h2A;
    tick();
    checks++;
    if (res_valid !== 1'b1 || res_data !== 14'h3FAA) begin
      failures++;
      $display("FAIL m1_pair got valid=%b data=%h exp valid=1 data=3faa", res_valid, res_data);
    end
    y_in = 8'h11;
    tick(2);
    checks++;
    if (res_data !== 14'h3FAA) begin
      failures++;
      $display("FAIL m1_hold_stall got %h exp 3faa", res_data);
    end
  endtask

  task automatic test_overflow;
    do_reset(1'b0);
    res_ready = 1'b0;
    tick(6);
    for (int i = 1; i <= 4; i++) begin
      y_in = 8'(i);
      tick();
    end
    checks++;
    if (overflow !== 1'b0 || res_valid !== 1'b1 || res_data !== 14'h0040) begin
      failures++;
      $display("FAIL ovf_full got o=%b v=%b d=%h exp o=0 v=1 d=0040", overflow, res_valid, res_data);
    end
    y_in = 8'h05;
    tick();
    checks++;
    if (overflow !== 1'b1 || res_data !== 14'h0040) begin
      failures++;
      $display("FAIL ovf_drop got o=%b d=%h exp o=1 d=0040", overflow, res_data);
    end
    res_ready = 1'b1;
    y_in      = 8'h0A;
    tick();
    checks++;
    if (res_data !== 14'h0080) begin
      failures++;
      $display("FAIL ovf_drain1 got %h exp 0080", res_data);
    end
    tick();
    checks++;
    if (res_data !== 14'h00C0) begin
      failures++;
      $display("FAIL ovf_drain2 got %h exp 00c0", res_data);
    end
    tick();
    checks++;
    if (res_data !== 14'h0100) begin
      failures++;
      $display("FAIL ovf_drain3 got %h exp 0100", res_data);
    end
    tick();
    checks++;
    if (res_data !== 14'h0280 || overflow !== 1'b1) begin
      failures++;
      $display("FAIL ovf_dropped_skip got d=%h o=%b exp d=0280 o=1", res_data, overflow);
    end
  endtask

  task automatic test_full_push_pop;
    do_reset(1'b0);
    res_ready = 1'b0;
    tick(6);
    for (int i = 1; i <= 4; i++) begin
      y_in = 8'(i);
      tick();
    end
    res_ready = 1'b1;
    y_in      = 8'h07;
    tick();
    checks++;
    if (overflow !== 1'b0 || res_data !== 14'h0080) begin
      failures++;
      $display("FAIL fpp_same_edge got o=%b d=%h exp o=0 d=0080", overflow, res_data);
    end
    res_ready = 1'b0;
    y_in      = 8'h09;
    tick();
    checks++;
    if (overflow !== 1'b1) begin
      failures++;
      $display("FAIL fpp_still_full got o=%b exp 1", overflow);
    end
    res_ready = 1'b1;
    y_in      = 8'h00;
    tick(3);
    checks++;
    if (res_data !== 14'h01C0) begin
      failures++;
      $display("FAIL fpp_tail got %h exp 01c0", res_data);
    end
  endtask

  task automatic test_reset_mid_pair;
    do_reset(1'b1);
    res_ready = 1'b1;
    tick(6);
    y_in = 8'hFE;
    tick();
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (running !== 1'b0 || res_valid !== 1'b0 || res_data !== 14'h0000 || overflow !== 1'b0) begin
      failures++;
      $display("FAIL rmp_async got r=%b v=%b d=%h o=%b exp all 0", running, res_valid, res_data, overflow);
    end
    y_in = 8'h2A;
    @(negedge clk);
    @(negedge clk);
    reset    = 1'b0;
    lsb_mode = 1'b1;
    y_in     = 8'h2A;
    tick(5);
    checks++;
    if (running !== 1'b0 || res_valid !== 1'b0) begin
      failures++;
      $display("FAIL rmp_setup got r=%b v=%b exp r=0 v=0", running, res_valid);
    end
    tick();
    y_in = 8'hFE;
    tick();
    checks++;
    if (res_valid !== 1'b0 || running !== 1'b1) begin
      failures++;
      $display("FAIL rmp_edge6 got v=%b r=%b exp v=0 r=1", res_valid, running);
    end
    y_in      = 8'h2A;
    res_ready = 1'b0;
    tick();
    checks++;
    if (res_valid !== 1'b1 || res_data !== 14'h3FAA) begin
      failures++;
      $display("FAIL rmp_edge7 got v=%b d=%h exp v=1 d=3faa", res_valid, res_data);
    end
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    reset     = 1'b0;
    y_in      = 8'h00;
    lsb_mode  = 1'b0;
    res_ready = 1'b0;
    test_reset();
    test_mode0_basic();
    test_mode1_latch();
    test_overflow();
    test_full_push_pop();
    test_reset_mid_pair();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
